// File: rtl/tmr0_wdt_prescaler.sv
// TMR0 / watchdog front end: holds OPTION, synchronizes and edge-detects
// the T0CKI pin, runs the shared 8-bit prescaler and the watchdog base
// counter, and produces the registered tmr0_inc / wdtmr strobes.
module tmr0_wdt_prescaler #(
    parameter int WDT_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       option_wr,
    input  logic [5:0] option_data,
    input  logic       tmr0_wr,
    input  logic       t0cki,
    input  logic       wdt_en,
    input  logic       CLRWDT,
    input  logic       SLEEP,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic [5:0] option_q,
    output logic [7:0] prescaler
);

    logic [5:0]          option_reg;
    logic [7:0]          presc_reg,   presc_next;
    logic                inc_reg,     inc_next;
    logic                wdtmr_reg,   wdtmr_next;
    logic [WDT_BITS-1:0] wdt_cnt_reg, wdt_cnt_next;
    logic [1:0]          inhibit_reg, inhibit_next;
    logic [2:0]          sync_reg;   // [0]=s1, [1]=s2, [2]=s3 (edge flop)

    // OPTION field decode
    logic       t0cs, t0se, psa;
    logic [2:0] ps;
    assign t0cs = option_reg[5];
    assign t0se = option_reg[4];
    assign psa  = option_reg[3];
    assign ps   = option_reg[2:0];

    // Prescaler masks: TMR0 divides by 2^(PS+1), WDT by 2^PS.
    logic [7:0] mask_tmr, mask_wdt;
    assign mask_tmr = 8'hFF >> (3'd7 - ps);
    assign mask_wdt = 8'hFF >> (4'd8 - {1'b0, ps});

    logic pin_evt, src_evt, evt_ok, clr, wdt_tick;
    assign pin_evt  = t0se ? (sync_reg[2] & ~sync_reg[1]) : (sync_reg[1] & ~sync_reg[2]);
    assign src_evt  = t0cs ? pin_evt : 1'b1;
    // Events in a TMR0 write cycle and the cycle after it are dropped.
    assign evt_ok   = src_evt & ~tmr0_wr & (inhibit_reg == 2'd0);
    assign clr      = CLRWDT | SLEEP;
    assign wdt_tick = wdt_en & (&wdt_cnt_reg) & ~clr;

    // Three-flop pin chain: two for metastability, third for edge detection.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            // Shift one stage of the T0CKI chain per clock
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= t0cki;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    // Next-state logic for strobes, prescaler, watchdog counter and inhibit
    always_comb begin
        inc_next     = 1'b0;
        wdtmr_next   = 1'b0;
        presc_next   = presc_reg;
        wdt_cnt_next = wdt_cnt_reg;
        inhibit_next = inhibit_reg;

        // Strobes always use the pre-write OPTION and prescaler values.
        if (psa) begin
            inc_next   = evt_ok;
            wdtmr_next = wdt_tick & ((presc_reg & mask_wdt) == mask_wdt);
        end else begin
            inc_next   = evt_ok & ((presc_reg & mask_tmr) == mask_tmr);
            wdtmr_next = wdt_tick;
        end

        // Prescaler: every clearing source wins over counting.
        if ((clr && psa) || option_wr || (tmr0_wr && !psa)) begin
            presc_next = 8'd0;
        end else if (psa ? wdt_tick : evt_ok) begin
            presc_next = presc_reg + 8'd1;
        end

        if (!wdt_en || clr) begin
            wdt_cnt_next = '0;
        end else begin
            wdt_cnt_next = wdt_cnt_reg + WDT_BITS'(1);
        end

        if (tmr0_wr) begin
            inhibit_next = 2'd1;
        end else if (inhibit_reg != 2'd0) begin
            inhibit_next = inhibit_reg - 2'd1;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            option_reg  <= 6'h3F;
            presc_reg   <= 8'd0;
            inc_reg     <= 1'b0;
            wdtmr_reg   <= 1'b0;
            wdt_cnt_reg <= '0;
            inhibit_reg <= 2'd0;
        end else begin
            if (option_wr) begin
                option_reg <= option_data;
            end
            presc_reg   <= presc_next;
            inc_reg     <= inc_next;
            wdtmr_reg   <= wdtmr_next;
            wdt_cnt_reg <= wdt_cnt_next;
            inhibit_reg <= inhibit_next;
        end
    end

    assign tmr0_inc  = inc_reg;
    assign wdtmr     = wdtmr_reg;
    assign option_q  = option_reg;
    assign prescaler = presc_reg;

endmodule
